mmio_ctrl: RTL and testbench

MMIO_CTRL -- requirements
Module: mmio_ctrl

---
 rtl/mmio_ctrl_pkg.sv | 20 ++
 rtl/mmio_rx_fifo.sv | 56 +++++
 rtl/mmio_ctrl.sv | 128 ++++++++++++
 tb/tb_mmio_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mmio_ctrl_pkg.sv
// mmio_ctrl_pkg: shared address map and status bit positions for mmio_ctrl.
// Contents: register byte offsets, status bit indices, counter width.
package mmio_ctrl_pkg;

  // Register byte offsets
  localparam int unsigned OFF_STATUS  = 32'h00;
  localparam int unsigned OFF_RX_DATA = 32'h04;
  localparam int unsigned OFF_TX_DATA = 32'h08;
  localparam int unsigned OFF_CYC_CNT = 32'h10;
  localparam int unsigned OFF_INS_CNT = 32'h14;
  localparam int unsigned OFF_CNT_RST = 32'h18;
  localparam int unsigned OFF_LEDS    = 32'h20;

  // Status register bit positions
  localparam int unsigned ST_TX_FREE  = 0;
  localparam int unsigned ST_RX_AVAIL = 1;

  localparam int unsigned CNT_W = 32;

endpackage

// File: rtl/mmio_rx_fifo.sv
// mmio_rx_fifo: circular buffer holding received UART bytes.
// Ports: clk, rst (async active-high), push_i/wdata_i (write side),
//        pop_i (read side), head_c (oldest entry, combinational),
//        full_c/empty_c (derived from the registered count).
// Push when full and pop when empty are ignored internally.
module mmio_rx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_c,
  output logic             full_c,
  output logic             empty_c
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign full_c  = (cnt_q == CW'(DEPTH));
  assign empty_c = (cnt_q == '0);
  assign head_c  = mem_q[rptr_q];
  assign do_push = push_i & ~full_c;
  assign do_pop  = pop_i & ~empty_c;

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PW'(1);
      if (do_pop)  rptr_q <= rptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset; validity is tracked by the count
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/mmio_ctrl.sv
// mmio_ctrl: memory-mapped peripheral block with LEDs, UART TX/RX and
// cycle/instruction counters.
// Ports: clk, rst (async active-high); bus en/addr/din/wbe -> dout (1-cycle
//        registered read data); inst_valid; leds; uart_tx_* valid/ready
//        source; uart_rx_* valid/ready sink buffered in mmio_rx_fifo.
// Build option: define MMIO_CTRL_COUNTERS_EN to include the cycle and
//        instruction counters; otherwise they read 0 and reset writes are no-ops.
module mmio_ctrl
  import mmio_ctrl_pkg::*;
#(
  parameter int unsigned DWIDTH   = 32,
  parameter int unsigned AWIDTH   = 10,
  parameter int unsigned N_LEDS   = 4,
  parameter int unsigned RX_DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [AWIDTH-1:0]   addr,
  input  logic [DWIDTH-1:0]   din,
  input  logic [DWIDTH/8-1:0] wbe,
  output logic [DWIDTH-1:0]   dout,
  input  logic                inst_valid,
  output logic [N_LEDS-1:0]   leds,
  output logic [7:0]          uart_tx_data,
  output logic                uart_tx_valid,
  input  logic                uart_tx_ready,
  input  logic [7:0]          uart_rx_data,
  input  logic                uart_rx_valid,
  output logic                uart_rx_ready
);

  logic              wr, rd;
  logic [DWIDTH-1:0] rdata_d, dout_q;
  logic [N_LEDS-1:0] leds_q;
  logic [7:0]        tx_data_q;
  logic              tx_valid_q;
  logic [7:0]        fifo_head;
  logic              fifo_full, fifo_empty, fifo_pop;

  assign wr = en & (|wbe);
  assign rd = en & ~(|wbe);

  assign fifo_pop      = rd && (addr == AWIDTH'(OFF_RX_DATA));
  assign uart_rx_ready = ~fifo_full;

  mmio_rx_fifo #(
    .WIDTH (8),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (uart_rx_valid & uart_rx_ready),
    .wdata_i (uart_rx_data),
    .pop_i   (fifo_pop),
    .head_c  (fifo_head),
    .full_c  (fifo_full),
    .empty_c (fifo_empty)
  );

`ifdef MMIO_CTRL_COUNTERS_EN
  logic [CNT_W-1:0] cyc_q, inst_q;
  logic             unused_ok;

  assign unused_ok = ^din;

  // Counter-reset write takes priority over the same-cycle increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q  <= '0;
      inst_q <= '0;
    end else if (wr && (addr == AWIDTH'(OFF_CNT_RST))) begin
      cyc_q  <= '0;
      inst_q <= '0;
    end else begin
      cyc_q <= cyc_q + CNT_W'(1);
      if (inst_valid) inst_q <= inst_q + CNT_W'(1);
    end
  end
`else
  logic unused_ok;

  assign unused_ok = ^{din, inst_valid};
`endif

  // Read data mux; unmapped and write-only addresses return 0
  always_comb begin
    rdata_d = '0;
    case (addr)
      AWIDTH'(OFF_STATUS): begin
        rdata_d[ST_TX_FREE]  = ~tx_valid_q;
        rdata_d[ST_RX_AVAIL] = ~fifo_empty;
      end
      AWIDTH'(OFF_RX_DATA): rdata_d = fifo_empty ? '0 : DWIDTH'(fifo_head);
`ifdef MMIO_CTRL_COUNTERS_EN
      AWIDTH'(OFF_CYC_CNT): rdata_d = DWIDTH'(cyc_q);
      AWIDTH'(OFF_INS_CNT): rdata_d = DWIDTH'(inst_q);
`endif
      AWIDTH'(OFF_LEDS):    rdata_d = DWIDTH'(leds_q);
      default:              rdata_d = '0;
    endcase
  end

  // Bus-facing registers: read data, LEDs and the TX holding byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q     <= '0;
      leds_q     <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      if (rd) dout_q <= rdata_d;
      if (wr && (addr == AWIDTH'(OFF_LEDS))) leds_q <= din[N_LEDS-1:0];
      if (tx_valid_q && uart_tx_ready) tx_valid_q <= 1'b0;
      // A new byte is only taken while the holding register is free
      if (wr && (addr == AWIDTH'(OFF_TX_DATA)) && !tx_valid_q) begin
        tx_data_q  <= din[7:0];
        tx_valid_q <= 1'b1;
      end
    end
  end

  assign dout          = dout_q;
  assign leds          = leds_q;
  assign uart_tx_data  = tx_data_q;
  assign uart_tx_valid = tx_valid_q;

endmodule

// File: tb/tb_mmio_ctrl.sv
// tb_mmio_ctrl: directed self-checking bench for mmio_ctrl.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_mmio_ctrl;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 10;
  localparam int unsigned NL = 4;
  localparam int unsigned RD = 8;

  logic          clk, rst, en, inst_valid;
  logic [AW-1:0] addr;
  logic [DW-1:0] din, dout;
  logic [3:0]    wbe;
  logic [NL-1:0] leds;
  logic [7:0]    uart_tx_data, uart_rx_data;
  logic          uart_tx_valid, uart_tx_ready, uart_rx_valid, uart_rx_ready;

  int checks   = 0;
  int failures = 0;
  logic [31:0] rv;

  mmio_ctrl #(.DWIDTH(DW), .AWIDTH(AW), .N_LEDS(NL), .RX_DEPTH(RD)) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .addr          (addr),
    .din           (din),
    .wbe           (wbe),
    .dout          (dout),
    .inst_valid    (inst_valid),
    .leds          (leds),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_valid (uart_tx_valid),
    .uart_tx_ready (uart_tx_ready),
    .uart_rx_data  (uart_rx_data),
    .uart_rx_valid (uart_rx_valid),
    .uart_rx_ready (uart_rx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
    en = 1'b1; addr = a; din = d; wbe = be;
    @(negedge clk);
    en = 1'b0; wbe = 4'h0; din = '0;
  endtask

  task automatic bus_read(input logic [AW-1:0] a, output logic [31:0] d);
    en = 1'b1; addr = a; wbe = 4'h0;
    @(negedge clk);
    en = 1'b0;
    d = dout;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; addr = '0; din = '0; wbe = '0; inst_valid = 1'b0;
    uart_tx_ready = 1'b0; uart_rx_data = '0; uart_rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_leds", 32'(leds), 32'h0);
    check("rst_dout", dout, 32'h0);
    check("rst_tx_valid", 32'(uart_tx_valid), 32'h0);
    check("rst_tx_data", 32'(uart_tx_data), 32'h0);
    check("rst_rx_ready", 32'(uart_rx_ready), 32'h1);
    bus_read(10'h00, rv); check("rst_status", rv, 32'h1);

    // LEDs
    bus_write(10'h20, 32'h5, 4'hF);
    check("leds_wr5", 32'(leds), 32'h5);
    bus_read(10'h20, rv); check("leds_rd5", rv, 32'h5);
    @(negedge clk);
    check("dout_hold", dout, 32'h5);
    bus_write(10'h20, 32'hFFFF_FFFA, 4'hF);
    check("leds_trunc", 32'(leds), 32'hA);
    bus_write(10'h20, 32'h3, 4'h1);
    check("leds_one_lane", 32'(leds), 32'h3);
    bus_write(10'h00, 32'hF, 4'hF);
    bus_write(10'h30, 32'hC, 4'hF);
    check("leds_unmapped_wr", 32'(leds), 32'h3);
    bus_read(10'h3C, rv); check("unmapped_rd", rv, 32'h0);

    // UART TX
    bus_write(10'h08, 32'h41, 4'hF);
    check("tx_valid_set", 32'(uart_tx_valid), 32'h1);
    check("tx_data_41", 32'(uart_tx_data), 32'h41);
    bus_read(10'h00, rv); check("status_tx_busy", rv, 32'h0);
    bus_read(10'h08, rv); check("tx_wo_read", rv, 32'h0);
    @(negedge clk);
    bus_write(10'h08, 32'h42, 4'hF);
    check("tx_drop_data", 32'(uart_tx_data), 32'h41);
    check("tx_drop_valid", 32'(uart_tx_valid), 32'h1);
    uart_tx_ready = 1'b1;
    @(negedge clk);
    uart_tx_ready = 1'b0;
    check("tx_valid_clear", 32'(uart_tx_valid), 32'h0);
    bus_read(10'h00, rv); check("status_tx_free", rv, 32'h1);

    // UART RX fill to full
    for (int i = 0; i < 8; i++) begin
      uart_rx_valid = 1'b1; uart_rx_data = 8'(8'h10 + i);
      @(negedge clk);
    end
    check("rx_full_ready", 32'(uart_rx_ready), 32'h0);
    uart_rx_data = 8'h99;
    @(negedge clk);
    uart_rx_valid = 1'b0;
    bus_read(10'h00, rv); check("status_rx_full", rv, 32'h3);
    // First pop while full with a byte offered: nothing may be pushed
    uart_rx_valid = 1'b1; uart_rx_data = 8'hAA;
    bus_read(10'h04, rv);
    uart_rx_valid = 1'b0;
    check("rx_pop0", rv, 32'h10);
    for (int i = 1; i < 8; i++) begin
      bus_read(10'h04, rv);
      check($sformatf("rx_pop%0d", i), rv, 32'(8'h10 + i));
    end
    bus_read(10'h04, rv); check("rx_pop_empty", rv, 32'h0);
    bus_read(10'h00, rv); check("status_rx_empty", rv, 32'h1);
    check("rx_ready_after", 32'(uart_rx_ready), 32'h1);

    // Simultaneous push and pop in the middle
    uart_rx_valid = 1'b1; uart_rx_data = 8'h21; @(negedge clk);
    uart_rx_data = 8'h22; @(negedge clk);
    uart_rx_data = 8'h23;
    bus_read(10'h04, rv);
    uart_rx_valid = 1'b0;
    check("rx_pp_21", rv, 32'h21);
    bus_read(10'h04, rv); check("rx_pp_22", rv, 32'h22);
    bus_read(10'h04, rv); check("rx_pp_23", rv, 32'h23);
    bus_read(10'h04, rv); check("rx_pp_empty", rv, 32'h0);

`ifdef MMIO_CTRL_COUNTERS_EN
    // Counter reset beats increment, then 100 cycles with alternating inst_valid
    inst_valid = 1'b1;
    bus_write(10'h18, 32'h0, 4'hF);
    inst_valid = 1'b0;
    bus_read(10'h10, rv); check("cyc_after_rst", rv, 32'h0);
    bus_read(10'h14, rv); check("inst_after_rst", rv, 32'h0);
    for (int i = 0; i < 100; i++) begin
      inst_valid = i[0];
      @(negedge clk);
    end
    inst_valid = 1'b0;
    bus_read(10'h10, rv); check("cyc_102", rv, 32'd102);
    bus_read(10'h14, rv); check("inst_50", rv, 32'd50);
    // Wrap
    force dut.cyc_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.cyc_q;
    bus_read(10'h10, rv); check("cyc_pre_wrap", rv, 32'hFFFF_FFFF);
    bus_read(10'h10, rv); check("cyc_wrap", rv, 32'h0);
`else
    inst_valid = 1'b1;
    repeat (5) @(negedge clk);
    inst_valid = 1'b0;
    bus_write(10'h18, 32'h0, 4'hF);
    check("cnt_rst_wr_noop", 32'(leds), 32'h3);
    bus_read(10'h10, rv); check("cyc_absent", rv, 32'h0);
    bus_read(10'h14, rv); check("inst_absent", rv, 32'h0);
`endif

    // Reset mid-operation
    bus_write(10'h08, 32'h55, 4'hF);
    check("tx_pending", 32'(uart_tx_valid), 32'h1);
    for (int i = 0; i < 3; i++) begin
      uart_rx_valid = 1'b1; uart_rx_data = 8'(8'h30 + i);
      @(negedge clk);
    end
    uart_rx_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_tx_valid", 32'(uart_tx_valid), 32'h0);
    check("midrst_leds", 32'(leds), 32'h0);
    check("midrst_dout", dout, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus_read(10'h00, rv); check("midrst_status", rv, 32'h1);
    bus_read(10'h04, rv); check("midrst_rx_empty", rv, 32'h0);
    check("midrst_rx_ready", 32'(uart_rx_ready), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
